// File: rtl/idli_seq_m_if.sv
// Sequencer-side signal bundle: SQI stream status and decode hints in,
// sync counter and per-word qualifiers out.
interface idli_seq_m_if;
  logic       i_sq_mem_vld;
  logic       i_sq_rhs_sqi;
  logic       i_sq_cond_wr;
  logic [1:0] i_sq_cond;
  logic       i_sq_p;
  logic       i_sq_redirect;
  logic [1:0] o_sq_ctr;
  logic       o_sq_enc_vld;
  logic       o_sq_imm;
  logic       o_sq_exec;
  logic       o_sq_flush;

  modport master (
    output i_sq_mem_vld, i_sq_rhs_sqi, i_sq_cond_wr, i_sq_cond, i_sq_p, i_sq_redirect,
    input  o_sq_ctr, o_sq_enc_vld, o_sq_imm, o_sq_exec, o_sq_flush
  );

  modport slave (
    input  i_sq_mem_vld, i_sq_rhs_sqi, i_sq_cond_wr, i_sq_cond, i_sq_p, i_sq_redirect,
    output o_sq_ctr, o_sq_enc_vld, o_sq_imm, o_sq_exec, o_sq_flush
  );
endinterface

// File: rtl/idli_seq_m.sv
// Instruction sequencer: GCK sync counter, encoding/immediate classification,
// conditional-execution state and PC-redirect flush handling.
package idli_pkg;
  typedef logic [1:0] ctr_t;
  typedef logic [1:0] cond_t;   // {en, pol}
  typedef enum logic {ST_WAIT, ST_RUN} seq_state_t;
endpackage

module idli_seq_m
  import idli_pkg::*;
(
  input  logic        i_sq_gck,
  input  logic        i_sq_rst_n,
  idli_seq_m_if.slave sq
);

  seq_state_t state_q, state_d;
  ctr_t       ctr_q, ctr_d;
  logic       dec_vld_q, dec_vld_d;
  cond_t      cond_q, cond_d;
  logic       flush_q, flush_d;

  logic run;
  logic imm;
  logic enc_vld;
  logic pass;
  logic exec;
  logic take_redirect;

  assign run           = (state_q == ST_RUN);
  assign imm           = run && dec_vld_q && sq.i_sq_rhs_sqi;
  assign enc_vld       = run && !imm;
  assign pass          = !cond_q[1] || (sq.i_sq_p == cond_q[0]);
  assign exec          = run && dec_vld_q && pass;
  assign take_redirect = (ctr_q == 2'd3) && exec && sq.i_sq_redirect;

  assign sq.o_sq_ctr     = ctr_q;
  assign sq.o_sq_enc_vld = enc_vld;
  assign sq.o_sq_imm     = imm;
  assign sq.o_sq_exec    = exec;
  assign sq.o_sq_flush   = flush_q;

  // NOTE: every variable gets its hold value before the case so no path leaves
  // one unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    dec_vld_d = dec_vld_q;
    cond_d    = cond_q;
    flush_d   = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        ctr_d = '0;
        // The flush cycle itself never accepts a restart of the stream.
        if (sq.i_sq_mem_vld && !flush_q) begin
          state_d = ST_RUN;
          ctr_d   = 2'd1;
        end
      end

      ST_RUN: begin
        if (!sq.i_sq_mem_vld) begin
          state_d   = ST_WAIT;
          ctr_d     = '0;
          dec_vld_d = 1'b0;
          cond_d    = '0;
        end else begin
          ctr_d = ctr_q + 2'd1;
          if (ctr_q == 2'd3) begin
            if (take_redirect) begin
              state_d   = ST_WAIT;
              ctr_d     = '0;
              dec_vld_d = 1'b0;
              cond_d    = '0;
              flush_d   = 1'b1;
            end else begin
              dec_vld_d = enc_vld;
              // Cond state is consumed by whichever instruction sees it.
              if (dec_vld_q)
                cond_d = (exec && sq.i_sq_cond_wr) ? cond_t'(sq.i_sq_cond) : '0;
            end
          end
        end
      end

      default: state_d = ST_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_sq_gck or negedge i_sq_rst_n) begin
    if (!i_sq_rst_n) begin
      state_q   <= ST_WAIT;
      ctr_q     <= '0;
      dec_vld_q <= 1'b0;
      cond_q    <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      dec_vld_q <= dec_vld_d;
      cond_q    <= cond_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_idli_seq_m.sv
// Directed bench for idli_seq_m: startup, immediates, CMPX/CEX conditions,
// redirect flush, skipped branch, async reset and stream drop.
module tb_idli_seq_m;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  idli_seq_m_if sq ();

  idli_seq_m dut (
    .i_sq_gck   (clk),
    .i_sq_rst_n (rst_n),
    .sq         (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  // {ctr, enc_vld, imm, exec, flush}
  function automatic logic [5:0] ev(input logic [1:0] c, input logic en,
                                    input logic im, input logic ex, input logic fl);
    return {c, en, im, ex, fl};
  endfunction

  task automatic check(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {sq.o_sq_ctr, sq.o_sq_enc_vld, sq.o_sq_imm, sq.o_sq_exec, sq.o_sq_flush};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed {ctr,enc,imm,exec,flush}=%b required %b", tag, observed, expected);
    end
  endtask

  // Entered at posedge+1 with inputs set; checks mid-cycle, then advances one cycle.
  task automatic cyc(input string tag, input logic [5:0] expected);
    #3;
    check(tag, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic period(input string tag, input logic en, input logic im, input logic ex);
    for (int c = 0; c < 4; c++)
      cyc(tag, ev(2'(c), en, im, ex, 1'b0));
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    sq.i_sq_mem_vld  = 1'b0;
    sq.i_sq_rhs_sqi  = 1'b0;
    sq.i_sq_cond_wr  = 1'b0;
    sq.i_sq_cond     = 2'b00;
    sq.i_sq_p        = 1'b0;
    sq.i_sq_redirect = 1'b0;

    #3;
    check("reset", ev(2'd0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_hold", ev(2'd0, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (3) cyc("idle_wait", ev(2'd0, 0, 0, 0, 0));

    // Startup: accepting cycle is ctr=0 in WAIT, first period has nothing to execute.
    sq.i_sq_mem_vld = 1'b1;
    cyc("start_accept", ev(2'd0, 0, 0, 0, 0));
    cyc("start_p1", ev(2'd1, 1, 0, 0, 0));
    cyc("start_p1", ev(2'd2, 1, 0, 0, 0));
    cyc("start_p1", ev(2'd3, 1, 0, 0, 0));
    period("start_p2_exec", 1, 0, 1);

    // Instruction with immediate, then the immediate word itself.
    sq.i_sq_rhs_sqi = 1'b1;
    period("imm_instr", 0, 1, 1);
    period("imm_word", 1, 0, 0);
    sq.i_sq_rhs_sqi = 1'b0;

    // CMPX writes 11; next instr skipped with P=0 and must not load cond; third executes.
    sq.i_sq_cond_wr = 1'b1;
    sq.i_sq_cond    = 2'b11;
    period("cmpx", 1, 0, 1);
    period("cmpx_skip", 1, 0, 0);
    sq.i_sq_cond    = 2'b10;
    period("cmpx_after", 1, 0, 1);

    // CEX 10 with P=0 on an instruction carrying an immediate.
    sq.i_sq_cond_wr = 1'b0;
    sq.i_sq_rhs_sqi = 1'b1;
    period("cex_imm_instr", 0, 1, 1);
    sq.i_sq_rhs_sqi = 1'b0;
    period("cex_imm_word", 1, 0, 0);

    // Branch with redirect plus a cond write in the same instruction; P=1 shows cond_q is 00.
    sq.i_sq_p        = 1'b1;
    sq.i_sq_redirect = 1'b1;
    sq.i_sq_cond_wr  = 1'b1;
    sq.i_sq_cond     = 2'b11;
    period("branch", 1, 0, 1);
    sq.i_sq_redirect = 1'b0;
    sq.i_sq_cond_wr  = 1'b0;
    sq.i_sq_p        = 1'b0;
    cyc("flush_pulse", ev(2'd0, 0, 0, 0, 1));
    cyc("flush_after", ev(2'd0, 0, 0, 0, 0));
    cyc("restart_p1", ev(2'd1, 1, 0, 0, 0));
    cyc("restart_p1", ev(2'd2, 1, 0, 0, 0));
    cyc("restart_p1", ev(2'd3, 1, 0, 0, 0));

    // P=0 executes, so the redirected branch did not leave 11 behind; load 11 now.
    sq.i_sq_cond_wr = 1'b1;
    sq.i_sq_cond    = 2'b11;
    period("redir_no_cond", 1, 0, 1);
    sq.i_sq_cond_wr  = 1'b0;
    sq.i_sq_redirect = 1'b1;
    period("skip_branch", 1, 0, 0);
    sq.i_sq_redirect = 1'b0;
    cyc("skip_no_flush", ev(2'd0, 1, 0, 1, 0));
    cyc("skip_no_flush", ev(2'd1, 1, 0, 1, 0));

    // Async reset in the ctr==2 cycle.
    rst_n = 1'b0;
    #1;
    check("async_rst", ev(2'd0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("async_rst_hold", ev(2'd0, 0, 0, 0, 0));
    rst_n           = 1'b1;
    sq.i_sq_mem_vld = 1'b0;
    repeat (2) cyc("post_rst_wait", ev(2'd0, 0, 0, 0, 0));
    sq.i_sq_mem_vld = 1'b1;
    cyc("post_rst_accept", ev(2'd0, 0, 0, 0, 0));
    cyc("post_rst_run", ev(2'd1, 1, 0, 0, 0));

    // Stream drops mid-period: back to WAIT with no flush.
    sq.i_sq_mem_vld = 1'b0;
    cyc("proto_err_cycle", ev(2'd2, 1, 0, 0, 0));
    cyc("proto_err_wait", ev(2'd0, 0, 0, 0, 0));
    cyc("proto_err_wait", ev(2'd0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/idli_seq_m.md
Name: idli_seq_m

Overview:
- Instruction sequencer for the nibble-serial core.
- Owns the 4-cycle GCK sync counter and decides whether each 16b SQI word is an instruction encoding or an immediate.
- Tracks conditional-execution state (CEX/CMPX), gates execution of the instruction in decode, and handles PC redirects by flushing and waiting for the memory stream to restart.
- Sits between the SQI memory interface, idli_decode_m (feeds its ctr/enc_vld) and the execution units (exec enable).

Parameters:
- None. All widths come from idli_pkg types: ctr_t 2b, cond_t 2b.

Ports:
- i_sq_gck  in  1  GCK; all flops posedge.
- i_sq_rst_n  in  1  reset, asynchronous, active-low.
- i_sq_mem_vld  in  1  SQI read stream delivering data nibbles this cycle.
- i_sq_rhs_sqi  in  1  decoded instruction's RHS is SRC_SQI, i.e. an immediate follows.
- i_sq_cond_wr  in  1  decoded instruction writes cond state.
- i_sq_cond  in  2  cond_t value from decode.
- i_sq_p  in  1  predicate register P; stable for the whole period.
- i_sq_redirect  in  1  executing instruction writes PC; sampled at ctr==3.
- o_sq_ctr  out  2  sync counter (ctr_t) to decode/datapath.
- o_sq_enc_vld  out  1  current word is an encoding; decode latches at ctr==3.
- o_sq_imm  out  1  current word is the immediate of the decoded instruction.
- o_sq_exec  out  1  decoded instruction is valid and its condition passes.
- o_sq_flush  out  1  one-cycle pulse: discard stream, memory must restart at the new PC.

Behaviour:
- Reset values: state=WAIT, ctr=0, dec_vld_q=0, cond_q=2'b00. All outputs 0.
- Period boundary = the cycle with ctr==3. All flop updates except ctr take effect there unless stated.
- FSM states: WAIT and RUN.
- WAIT:
  - ctr held at 0; enc_vld=imm=exec=0.
  - When i_sq_mem_vld=1, go to RUN. That cycle counts as ctr=0 of the first period, so ctr=1 on the next cycle.
- RUN:
  - ctr increments every cycle and wraps 3->0.
  - If i_sq_mem_vld=0 in RUN: protocol error; go to WAIT, ctr<=0, dec_vld_q<=0, cond_q<=0. No flush pulse.
- dec_vld_q means decode holds a valid instruction for the current period.
  - At ctr==3: dec_vld_q <= o_sq_enc_vld && !take_redirect.
- Immediate handling:
  - o_sq_imm = RUN && dec_vld_q && i_sq_rhs_sqi.
  - o_sq_enc_vld = RUN && !o_sq_imm. An immediate word is never latched as an encoding.
  - A skipped (cond-failed) instruction still consumes its immediate.
- Condition:
  - cond_t = {en,pol}.
  - pass = !cond_q[1] || (i_sq_p == cond_q[0]).
  - o_sq_exec = RUN && dec_vld_q && pass.
- cond_q update at ctr==3 when dec_vld_q:
  - if o_sq_exec && i_sq_cond_wr: load i_sq_cond;
  - else: clear to 00 (consumed by this instruction, executed or skipped).
  - cond_q is unchanged across immediate words and invalid periods.
- Redirect:
  - take_redirect = ctr==3 && o_sq_exec && i_sq_redirect.
  - A skipped instruction never redirects.
  - On take_redirect: state<=WAIT, ctr<=0, dec_vld_q<=0, cond_q<=0, o_sq_flush<=1 for exactly one cycle.
  - Redirect wins over cond_wr in the same cycle.
- Simultaneous i_sq_mem_vld in the flush cycle: flush has priority. WAIT is entered; the mem_vld rising edge is accepted only from the following cycle.
- Async reset mid-period: everything returns immediately to reset values. No flush is issued.

Test Plan:
- Reset then i_sq_mem_vld=1 at cycle 5 -> ctr 0,1,2,3,0 from cycle 5; enc_vld=1, exec=0 in the first period; exec=1 in the second.
- Valid instr with rhs_sqi=1 -> during its period imm=1, enc_vld=0. The following period has dec_vld_q=0 (exec=0); the next word is treated as an encoding again.
- CMPX (cond_wr=1, cond=11) then next instr with P=0 -> exec=0 for it, cond_q cleared; the third instr executes with exec=1.
- CEX cond=10, P=0, next instr has immediate -> instr exec=1; immediate period imm=1; cond_q=00 afterwards.
- Branch with redirect=1 at ctr==3 -> flush=1 for one cycle, state WAIT, ctr=0, exec=0 until mem_vld. A cond-failed branch with redirect=1 -> no flush.
- i_sq_rst_n low at ctr==2 mid-RUN -> all outputs 0 asynchronously; after release, WAIT until mem_vld.
